// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, parity codes and counter helpers
// for the UART RX control path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned DEF_COUNTER_WIDTH = 3;

    function automatic int unsigned cnt_max(input int unsigned cw);
        return (32'd1 << cw) - 32'd1;
    endfunction

    function automatic int unsigned cnt_mid(input int unsigned cw);
        return 32'd1 << (cw - 32'd1);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: control-stage to deserializer bundle of the UART RX path.
// master = uart_rx_ctrl, slave = deserializer / status consumers.
interface uart_rx_if #(
    parameter int COUNTER_WIDTH = 3
);
    logic                     deser_en;
    logic                     sampled_bit;
    logic [COUNTER_WIDTH-1:0] edg_cnt;
    logic                     data_valid;
    logic                     par_err;
    logic                     stp_err;
    logic                     busy;

    modport master (
        output deser_en, sampled_bit, edg_cnt,
        output data_valid, par_err, stp_err, busy
    );

    modport slave (
        input deser_en, sampled_bit, edg_cnt,
        input data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: captures the line around mid-bit and registers the
// 2-of-3 majority, rejecting single-sample glitches.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int COUNTER_WIDTH = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     rx,
    input  logic [COUNTER_WIDTH-1:0] edg_cnt,
    output logic                     sampled_bit
);

    localparam logic [COUNTER_WIDTH-1:0] MID =
        COUNTER_WIDTH'(cnt_mid(COUNTER_WIDTH));
    localparam logic [COUNTER_WIDTH-1:0] S0_AT   = MID - 1'b1;
    localparam logic [COUNTER_WIDTH-1:0] S1_AT   = MID;
    localparam logic [COUNTER_WIDTH-1:0] VOTE_AT = MID + 1'b1;

    logic s0;
    logic s1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0          <= 1'b0;
            s1          <= 1'b0;
            sampled_bit <= 1'b0;
        end else begin
            unique case (1'b1)
                edg_cnt == S0_AT:   s0 <= rx;
                edg_cnt == S1_AT:   s1 <= rx;
                edg_cnt == VOTE_AT:
                    sampled_bit <= (s0 & s1) | (s0 & rx) | (s1 & rx);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART RX control stage (start detect, bit timing, parity/stop).
// Define UART_RX_SYNC_EN to add a 2-flop input synchroniser on RX_IN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int COUNTER_WIDTH = 3
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     RX_IN,
    input  logic     PAR_EN,
    input  logic     PAR_TYP,
    uart_rx_if.master rx
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [COUNTER_WIDTH-1:0] MAX =
        COUNTER_WIDTH'(cnt_max(COUNTER_WIDTH));
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

    state_t                   state;
    logic [COUNTER_WIDTH-1:0] edg_q;
    logic [BW-1:0]            bit_cnt;
    logic                     par_en_q;
    logic                     par_typ_q;
    logic                     par_acc;
    logic                     deser_en_q;
    logic                     busy_q;
    logic                     dv_q;
    logic                     pe_q;
    logic                     se_q;
    logic                     rx_s;
    logic                     sbit;
    logic                     at_max;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], RX_IN};
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    uart_rx_sampler #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .rx         (rx_s),
        .edg_cnt    (edg_q),
        .sampled_bit(sbit)
    );

    assign at_max = (edg_q == MAX);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            edg_q      <= '0;
            bit_cnt    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_acc    <= 1'b0;
            deser_en_q <= 1'b0;
            busy_q     <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            edg_q <= (state == IDLE) ? '0 : edg_q + 1'b1;
            unique case (state)
                IDLE: if (!rx_s) begin
                    state     <= START;
                    busy_q    <= 1'b1;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    par_acc   <= 1'b0;
                    bit_cnt   <= '0;
                    pe_q      <= 1'b0;
                    se_q      <= 1'b0;
                end
                // a start bit that votes high was only a glitch
                START: if (at_max) begin
                    if (sbit) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state      <= DATA;
                        deser_en_q <= 1'b1;
                    end
                end
                DATA: if (at_max) begin
                    par_acc <= par_acc ^ sbit;
                    if (bit_cnt == LAST) begin
                        bit_cnt    <= '0;
                        deser_en_q <= 1'b0;
                        state      <= par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: if (at_max) begin
                    pe_q  <= sbit != (par_acc ^ (par_typ_q == PAR_ODD));
                    state <= STOP;
                end
                STOP: if (at_max) begin
                    se_q   <= ~sbit;
                    dv_q   <= sbit & ~pe_q;
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.deser_en    = deser_en_q;
    assign rx.sampled_bit = sbit;
    assign rx.edg_cnt     = edg_q;
    assign rx.data_valid  = dv_q;
    assign rx.par_err     = pe_q;
    assign rx.stp_err     = se_q;
    assign rx.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: table vectors, corner sequences and random frames
// checked against a frame-level reference model and a deserializer model.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int DW   = 8;
    localparam int CW   = 3;
    localparam int MAXC = 7;
`ifdef UART_RX_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic CLK     = 1'b0;
    logic RST     = 1'b0;
    logic RX_IN   = 1'b1;
    logic PAR_EN  = 1'b0;
    logic PAR_TYP = 1'b0;

    uart_rx_if #(.COUNTER_WIDTH(CW)) rx();

    uart_rx_ctrl #(
        .DATA_WIDTH   (DW),
        .COUNTER_WIDTH(CW)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .RX_IN  (RX_IN),
        .PAR_EN (PAR_EN),
        .PAR_TYP(PAR_TYP),
        .rx     (rx)
    );

    always #5 CLK = ~CLK;

    // deserializer: LSB-first shift at the last edge of each data bit
    logic [DW-1:0] p_data = '0;
    always @(posedge CLK)
        if (rx.deser_en && rx.edg_cnt == CW'(MAXC))
            p_data <= {rx.sampled_bit, p_data[DW-1:1]};

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic       pb;
        logic       sb;
        int         gl;
        logic       ev;
        logic       epe;
        logic       ese;
    } vec_t;

    function automatic logic exp_parity(input logic [7:0] d, input logic pt);
        int ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(d[k]);
        return logic'(ones % 2) ^ pt;
    endfunction

    task automatic wait_idle();
        int w = 0;
        @(negedge CLK);
        while (rx.busy && w < 200) begin
            @(negedge CLK);
            w++;
        end
        check("idle_before_frame", rx.busy, 0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d,
                             input logic pe, input logic pt,
                             input logic pb, input logic sb,
                             input int gl, input int rst_at,
                             input logic ev, input logic epe,
                             input logic ese, input logic flip);
        logic line[$];
        int   nb;
        int   n;
        int   dv_n = 0;
        int   dv_at = -1;
        int   den = 0;
        line.push_back(1'b0);
        for (int k = 0; k < DW; k++) line.push_back(d[k]);
        if (pe) line.push_back(pb);
        line.push_back(sb);
        nb = line.size();
        n  = nb * 8 + L + 4;
        wait_idle();
        PAR_EN  = pe;
        PAR_TYP = pt;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) @(negedge CLK);
            if (rx.data_valid) begin
                dv_n++;
                dv_at = i;
            end
            if (rx.deser_en) den++;
            if (i == L + 1)
                check({tag, "_start_clr"},
                      {rx.busy, rx.par_err, rx.stp_err}, 3'b100);
            if (i == rst_at) begin
                RST = 1'b0;
                #1;
                check({tag, "_rst_outs"},
                      {rx.deser_en, rx.sampled_bit, rx.edg_cnt,
                       rx.data_valid, rx.par_err, rx.stp_err, rx.busy}, 0);
                RX_IN = 1'b1;
                @(negedge CLK);
                check({tag, "_rst_no_dv"}, rx.data_valid, 0);
                RST = 1'b1;
                return;
            end
            RX_IN = (i / 8 < nb) ? line[i / 8] : 1'b1;
            if (i == gl) RX_IN = 1'b0;
            if (flip && i == 20) begin
                PAR_EN  = ~PAR_EN;
                PAR_TYP = ~PAR_TYP;
            end
        end
        check({tag, "_dv_count"}, dv_n, {31'd0, ev});
        if (ev) begin
            check({tag, "_dv_cycle"}, dv_at, 8 * nb + 1 + L);
            check({tag, "_p_data"}, p_data, d);
        end
        check({tag, "_par_err"}, rx.par_err, epe);
        check({tag, "_stp_err"}, rx.stp_err, ese);
        check({tag, "_deser_en_len"}, den, DW * 8);
    endtask

    task automatic glitch_start();
        int den = 0;
        int dvn = 0;
        wait_idle();
        for (int i = 0; i <= L + 12; i++) begin
            if (i > 0) @(negedge CLK);
            den += int'(rx.deser_en);
            dvn += int'(rx.data_valid);
            if (i == L + 8)
                check("glitch_edg_max", {rx.busy, rx.edg_cnt}, {1'b1, 3'd7});
            if (i == L + 9)
                check("glitch_idle",
                      {rx.busy, rx.edg_cnt, rx.par_err, rx.stp_err}, 0);
            RX_IN = (i < 3) ? 1'b0 : 1'b1;
        end
        check("glitch_no_deser", den, 0);
        check("glitch_no_dv", dvn, 0);
    endtask

    vec_t tv[8];

    initial begin
        tv[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0};
        tv[1] = '{8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0};
        tv[2] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0};
        tv[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1};
        tv[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 13, 1'b1, 1'b0, 1'b0};
        tv[5] = '{8'h96, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0};
        tv[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0};
        tv[7] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b1, 1'b1};

        repeat (3) @(negedge CLK);
        check("reset_outs",
              {rx.deser_en, rx.sampled_bit, rx.edg_cnt, rx.data_valid,
               rx.par_err, rx.stp_err, rx.busy}, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("idle_edg_held", {rx.busy, rx.edg_cnt}, 0);

        for (int v = 0; v < 8; v++)
            run_frame($sformatf("tv%0d", v), tv[v].d, tv[v].pe, tv[v].pt,
                      tv[v].pb, tv[v].sb, tv[v].gl, -1,
                      tv[v].ev, tv[v].epe, tv[v].ese, 1'b0);

        glitch_start();

        run_frame("rst_mid", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, 44,
                  1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("after_rst", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1,
                  1'b1, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            logic [7:0] d;
            logic pe, pt, pb, sb, fl, epe, ese;
            d   = 8'($urandom);
            pe  = 1'($urandom_range(0, 1));
            pt  = 1'($urandom_range(0, 1));
            pb  = 1'($urandom_range(0, 1));
            sb  = ($urandom_range(0, 5) != 0);
            fl  = 1'($urandom_range(0, 1));
            epe = pe && (pb != exp_parity(d, pt));
            ese = !sb;
            run_frame($sformatf("rnd%0d", r), d, pe, pt, pb, sb, -1, -1,
                      !epe && !ese, epe, ese, fl);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side control stage of the UART RX path. It sits directly upstream of the deserializer and drives its Enable, Sbit and edg_cnt inputs. It oversamples RX_IN, detects start bits, rejects glitches and majority-votes each bit. It sequences start, data, optional parity and stop, and reports data_valid, par_err and stp_err per frame.

Parameters:
DATA_WIDTH, 8, data bits per frame (LSB first); must match the deserializer.
COUNTER_WIDTH, 3, edge counter width; oversampling ratio = 2**COUNTER_WIDTH; must be >= 3.

Ports:
CLK  in  1  oversampling clock (2**COUNTER_WIDTH x baud)
RST  in  1  asynchronous, active-low reset
RX_IN  in  1  serial line, idle high
PAR_EN  in  1  1 = frame carries a parity bit
PAR_TYP  in  1  0 = even, 1 = odd
deser_en  out  1  deserializer Enable
sampled_bit  out  1  majority-voted bit value, deserializer Sbit
edg_cnt  out  COUNTER_WIDTH  oversample edge count within the current bit
data_valid  out  1  one-cycle pulse: frame complete, no errors
par_err  out  1  parity mismatch on the last frame
stp_err  out  1  stop bit sampled low on the last frame
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; bit counter 0; latched PAR_EN/PAR_TYP 0.
- Definitions: MAX = 2**COUNTER_WIDTH-1; MID = 2**(COUNTER_WIDTH-1).
- edg_cnt:
  - Held at 0 in IDLE.
  - In all other states it increments every clock and wraps MAX->0; each wrap ends one bit period.
- Sampler:
  - Captures RX_IN at edg_cnt = MID-1, MID and MID+1.
  - At the clock edge ending edg_cnt = MID+1, sampled_bit registers the 2-of-3 majority.
  - sampled_bit is stable from MID+2 through MAX, so the deserializer's shift at edg_cnt == MAX sees the settled value.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: RX_IN == 0 -> START, edg_cnt = 0; PAR_EN and PAR_TYP are latched here. Mid-frame changes to them are ignored.
  - START: at edg_cnt == MAX, if sampled_bit == 1 the start was a glitch -> IDLE with no error flags; otherwise -> DATA.
  - DATA: deser_en = 1. The bit counter increments at each edg_cnt == MAX. After DATA_WIDTH bits -> PARITY if latched PAR_EN, else STOP.
  - PARITY: expected parity = XOR of the sampled data bits (even), inverted for odd. At edg_cnt == MAX, par_err <= (sampled_bit != expected) -> STOP.
  - STOP: at edg_cnt == MAX, stp_err <= ~sampled_bit. data_valid pulses for 1 clock when neither par_err nor stp_err is set for this frame -> IDLE.
- Error flags: par_err and stp_err hold until the next entry to START, where both clear.
- data_valid and the error flags assert in the same cycle. The deserializer's P_DATA is stable while data_valid is high.
- Back-to-back frames: STOP always returns to IDLE. A start edge present at that point is detected one clock later; this 1-clock slip is within oversampling tolerance.
- Reset mid-frame: immediate return to IDLE with all outputs 0; no partial data_valid.
- Latency, no parity: the cycle in which IDLE sees RX_IN = 0 is cycle 0. data_valid is high in cycle 81 (start bit, 8 data bits and stop bit at 8 clocks each).
- Latency, with parity: data_valid is high in cycle 89.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through an internal 2-flop synchroniser, reset to 1, before any use. All latencies grow by 2 clocks.
- Undefined: RX_IN is used directly; the integrator guarantees it is synchronous to CLK.

Decomposition:
- Shared package uart_rx_pkg:
  - state encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3-bit)
  - PAR_EVEN = 0, PAR_ODD = 1
  - helper constants for MAX and MID derived from COUNTER_WIDTH
- One sub-module, uart_rx_sampler: 3-point capture plus majority vote, driven by edg_cnt.

Test Plan:
- PAR_EN=0, send 0xA5 -> deser_en high for 64 clocks; data_valid in cycle 81; deserializer P_DATA = 0xA5; par_err = stp_err = 0.
- PAR_EN=1, PAR_TYP=0, send 0x0F with parity bit 0 -> data_valid in cycle 89, P_DATA = 0x0F. Repeat with parity bit 1 -> par_err = 1, no data_valid.
- Stop bit driven low, data 0x3C -> stp_err = 1, no data_valid; stp_err clears on the next frame's START.
- RX_IN low for 3 clocks then high (glitch) -> START aborts at edg_cnt = 7, back to IDLE, no flags, deser_en never asserted.
- A single-clock low pulse at edg_cnt = MID inside data bit value 1 of frame 0x55 -> majority keeps 1; P_DATA = 0x55.
- RST asserted at data bit 4 of a frame -> all outputs 0 immediately; a following clean frame 0xC3 is received correctly.
